// File: rtl/cpu_pkg.sv
// Shared IF-stage constants: boot address, sequential step and fetch FSM encoding.
package cpu_pkg;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'hBFC0_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

  typedef logic [1:0] if_state_t;
  localparam if_state_t S_BOOT       = 2'd0;
  localparam if_state_t S_RUN        = 2'd1;
  localparam if_state_t S_HOLD       = 2'd2;
  localparam if_state_t S_HOLD_REDIR = 2'd3;
endpackage

// File: rtl/if_redirect_pend.sv
// Deferred-branch holder plus next fetch PC selection (flush > branch > pending > sequential).
module if_redirect_pend
  import cpu_pkg::*;
#(
  parameter logic [31:0] PC_STEP = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        capture,
  input  logic        clear,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  input  logic [31:0] fetch_pc,
  output logic        pend_valid,
  output logic [31:0] next_pc
);
  logic [31:0] pend_pc;

  // clear beats capture, so a flush in the same cycle as a stalled branch drops it
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_valid <= 1'b0;
      pend_pc    <= 32'd0;
    end else if (clear) begin
      pend_valid <= 1'b0;
    end else if (capture) begin
      pend_valid <= 1'b1;
      pend_pc    <= br_target;
    end
  end

  always_comb begin
    next_pc = fetch_pc + PC_STEP;
    if (flush)            next_pc = flush_pc;
    else if (br_redirect) next_pc = br_target;
    else if (pend_valid)  next_pc = pend_pc;
  end
endmodule

// File: rtl/if_fetch_unit.sv
// IF-stage fetch initiator: drives the 1-cycle-latency inst SRAM and tracks the PC presented to ID.
module if_fetch_unit
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ID_stall,
  input  logic        br_redirect,
  input  logic [31:0] br_target,
  input  logic        flush,
  input  logic [31:0] flush_pc,
  output logic        inst_sram_en,
  output logic [3:0]  inst_sram_wen,
  output logic [31:0] inst_sram_addr,
  output logic [31:0] inst_sram_wdata,
  output logic [31:0] ID_pc,
  output logic        ID_valid,
  output logic        ID_adel,
  output if_state_t   state
);
  logic [31:0] fetch_pc;
  logic [31:0] next_pc;
  logic        pend_valid;
  logic        running;
  logic        capture;
  logic        clear;

  // Handshake: ID accepts the presented instruction in any cycle with ID_stall=0;
  // while stalled the same fetch address is re-issued so the SRAM output stays aligned.
  assign running = (state != S_BOOT);
  assign capture = running & ID_stall & br_redirect;
  assign clear   = running & (flush | (~ID_stall & pend_valid));

  if_redirect_pend #(.PC_STEP(PC_STEP)) u_pend (
    .clk         (clk),
    .rst         (rst),
    .capture     (capture),
    .clear       (clear),
    .br_redirect (br_redirect),
    .br_target   (br_target),
    .flush       (flush),
    .flush_pc    (flush_pc),
    .fetch_pc    (fetch_pc),
    .pend_valid  (pend_valid),
    .next_pc     (next_pc)
  );

  assign inst_sram_en    = ~rst;
  assign inst_sram_wen   = 4'b0000;
  assign inst_sram_wdata = 32'd0;
  assign inst_sram_addr  = {fetch_pc[31:2], 2'b00};

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc <= RESET_PC;
      ID_pc    <= 32'd0;
      ID_valid <= 1'b0;
      ID_adel  <= 1'b0;
      state    <= S_BOOT;
    end else if (state == S_BOOT) begin
      fetch_pc <= RESET_PC + PC_STEP;
      ID_pc    <= RESET_PC;
      ID_valid <= 1'b1;
      ID_adel  <= (RESET_PC[1:0] != 2'b00);
      state    <= S_RUN;
    end else if (flush) begin
      fetch_pc <= next_pc;
      ID_pc    <= fetch_pc;
      ID_valid <= 1'b0;
      ID_adel  <= 1'b0;
      state    <= S_RUN;
    end else if (!ID_stall) begin
      fetch_pc <= next_pc;
      ID_pc    <= fetch_pc;
      ID_valid <= 1'b1;
      ID_adel  <= (fetch_pc[1:0] != 2'b00);
      state    <= S_RUN;
    end else begin
      state <= (pend_valid | br_redirect) ? S_HOLD_REDIR : S_HOLD;
    end
  end
endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed walk through the fetch scenarios, then randomized stall/branch/flush/reset traffic.
module tb_if_fetch_unit;
  localparam logic [31:0] RST_PC = 32'hBFC0_0000;

  logic        clk;
  logic        rst;
  logic        ID_stall;
  logic        br_redirect;
  logic [31:0] br_target;
  logic        flush;
  logic [31:0] flush_pc;
  logic        inst_sram_en;
  logic [3:0]  inst_sram_wen;
  logic [31:0] inst_sram_addr;
  logic [31:0] inst_sram_wdata;
  logic [31:0] ID_pc;
  logic        ID_valid;
  logic        ID_adel;
  logic [1:0]  state;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .ID_stall        (ID_stall),
    .br_redirect     (br_redirect),
    .br_target       (br_target),
    .flush           (flush),
    .flush_pc        (flush_pc),
    .inst_sram_en    (inst_sram_en),
    .inst_sram_wen   (inst_sram_wen),
    .inst_sram_addr  (inst_sram_addr),
    .inst_sram_wdata (inst_sram_wdata),
    .ID_pc           (ID_pc),
    .ID_valid        (ID_valid),
    .ID_adel         (ID_adel),
    .state           (state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // reference model
  logic [31:0] exp_q[$];
  logic [31:0] m_fetch;
  logic [31:0] m_id_pc;
  logic        m_id_valid;
  logic        m_adel;
  logic        m_booted;
  logic        m_holding;
  logic        m_pend_v;
  logic [31:0] m_pend_pc;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [1:0] model_state();
    if (!m_booted) return 2'd0;
    if (m_pend_v)  return 2'd3;
    if (m_holding) return 2'd2;
    return 2'd1;
  endfunction

  task automatic model_step();
    if (rst) begin
      m_fetch = RST_PC; m_id_pc = 32'd0; m_id_valid = 1'b0; m_adel = 1'b0;
      m_booted = 1'b0; m_holding = 1'b0; m_pend_v = 1'b0; m_pend_pc = 32'd0;
    end else if (!m_booted) begin
      m_id_pc = RST_PC; m_id_valid = 1'b1; m_adel = 1'b0;
      m_fetch = RST_PC + 32'd4; m_booted = 1'b1;
    end else if (flush) begin
      m_id_pc = m_fetch; m_id_valid = 1'b0; m_adel = 1'b0;
      m_fetch = flush_pc; m_pend_v = 1'b0; m_holding = 1'b0;
    end else if (!ID_stall) begin
      m_id_pc = m_fetch; m_id_valid = 1'b1; m_adel = (m_fetch % 4) != 0;
      if (br_redirect)   m_fetch = br_target;
      else if (m_pend_v) m_fetch = m_pend_pc;
      else               m_fetch = m_fetch + 32'd4;
      m_pend_v = 1'b0; m_holding = 1'b0;
    end else begin
      if (br_redirect) begin
        m_pend_v = 1'b1; m_pend_pc = br_target;
      end
      m_holding = 1'b1;
    end
    exp_q.push_back(m_id_pc);
  endtask

  task automatic check_all();
    logic [31:0] exp_id;
    exp_id = (exp_q.size() > 0) ? exp_q.pop_front() : 32'hDEAD_BEEF;
    check("en",    {31'd0, inst_sram_en}, {31'd0, ~rst});
    check("wen",   {28'd0, inst_sram_wen}, 32'd0);
    check("wdata", inst_sram_wdata, 32'd0);
    check("addr",  inst_sram_addr, m_fetch & 32'hFFFF_FFFC);
    check("id_valid", {31'd0, ID_valid}, {31'd0, m_id_valid});
    if (m_id_valid) check("id_pc", ID_pc, exp_id);
    check("id_adel", {31'd0, ID_adel}, {31'd0, m_adel});
    check("state", {30'd0, state}, {30'd0, model_state()});
  endtask

  // driver tasks
  task automatic drive(input logic r, input logic st, input logic rd, input logic [31:0] tg,
                       input logic fl, input logic [31:0] fp);
    rst = r; ID_stall = st; br_redirect = rd; br_target = tg; flush = fl; flush_pc = fp;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check_all();
  endtask

  task automatic idle_tick();
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
  endtask

  function automatic logic [31:0] rand_target();
    int sel;
    sel = $urandom_range(0, 9);
    if (sel == 0) return 32'hFFFF_FFF0 + {$urandom_range(0, 15)};
    if (sel == 1) return $urandom();
    return {$urandom()} & 32'hFFFF_FFFC;
  endfunction

  initial begin
    drive(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    tick();
    check("rst_en", {31'd0, inst_sram_en}, 32'd0);

    // reset release, boot cycle
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1;
    check("boot_addr", inst_sram_addr, 32'hBFC0_0000);
    check("boot_valid", {31'd0, ID_valid}, 32'd0);
    tick();
    check("c1_addr", inst_sram_addr, 32'hBFC0_0004);
    check("c1_id_pc", ID_pc, 32'hBFC0_0000);
    idle_tick();
    check("c2_id_pc", ID_pc, 32'hBFC0_0004);

    // three stall cycles, then release
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
      tick();
      check("stall_addr", inst_sram_addr, 32'hBFC0_0008);
      check("stall_id_pc", ID_pc, 32'hBFC0_0004);
    end
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'd0);
    #1 check("release_addr", inst_sram_addr, 32'hBFC0_0008);
    tick();
    check("after_release_id_pc", ID_pc, 32'hBFC0_0008);

    // unstalled redirect with delay slot
    drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0100, 1'b0, 32'd0);
    tick();
    check("delay_slot_id_pc", ID_pc, 32'hBFC0_000C);
    check("redir_addr", inst_sram_addr, 32'hBFC0_0100);
    idle_tick();
    check("target_id_pc", ID_pc, 32'hBFC0_0100);

    // redirect during first of two stall cycles
    drive(1'b0, 1'b1, 1'b1, 32'h8000_1000, 1'b0, 32'd0);
    tick();
    check("hold_redir_state", {30'd0, state}, 32'd3);
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    check("hold_redir_addr", inst_sram_addr, 32'hBFC0_0104);
    idle_tick();
    check("deferred_addr", inst_sram_addr, 32'h8000_1000);
    check("deferred_id_pc", ID_pc, 32'hBFC0_0104);

    // flush while stalled with a pending redirect
    drive(1'b0, 1'b1, 1'b1, 32'h1234_5678, 1'b0, 32'd0);
    tick();
    drive(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'hBFC0_0380);
    tick();
    check("flush_addr", inst_sram_addr, 32'hBFC0_0380);
    check("flush_bubble", {31'd0, ID_valid}, 32'd0);
    check("flush_state", {30'd0, state}, 32'd1);
    idle_tick();
    check("flush_id_pc", ID_pc, 32'hBFC0_0380);
    check("flush_id_valid", {31'd0, ID_valid}, 32'd1);

    // misaligned branch target
    drive(1'b0, 1'b0, 1'b1, 32'hBFC0_0102, 1'b0, 32'd0);
    tick();
    check("misal_addr", inst_sram_addr, 32'hBFC0_0100);
    idle_tick();
    check("misal_id_pc", ID_pc, 32'hBFC0_0102);
    check("misal_adel", {31'd0, ID_adel}, 32'd1);

    // sequential wrap at the top of the address space
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'hFFFF_FFFC);
    tick();
    idle_tick();
    check("wrap_addr", inst_sram_addr, 32'd0);
    check("wrap_id_pc", ID_pc, 32'hFFFF_FFFC);

    // reset with a pending redirect, then a flush in the boot cycle is ignored
    drive(1'b0, 1'b1, 1'b1, 32'h0000_4000, 1'b0, 32'd0);
    tick();
    drive(1'b1, 1'b1, 1'b0, 32'd0, 1'b0, 32'd0);
    tick();
    check("mid_rst_state", {30'd0, state}, 32'd0);
    drive(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h0000_0800);
    tick();
    check("boot_flush_addr", inst_sram_addr, 32'hBFC0_0004);
    idle_tick();
    check("no_stale_pend_addr", inst_sram_addr, 32'hBFC0_0008);

    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 199) == 0,
            $urandom_range(0, 9) < 3,
            $urandom_range(0, 99) < 15,
            rand_target(),
            $urandom_range(0, 99) < 5,
            rand_target());
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
